// File: rtl/chunked_serial_adder_pkg.sv
// Shared definitions for the chunk-serial arithmetic blocks.
//   state_t        : FSM encoding (IDLE / RUN / DONE).
//   serial_nchunk  : number of CHUNK-bit slices in a WIDTH-bit word.
//   serial_cw      : width of a counter that indexes those slices (at least 1).
package chunked_serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A zero chunk is rejected by the top-level parameter check; returning 1
  // here only keeps the division well defined while that check fires.
  function automatic int serial_nchunk(input int width, input int chunk);
    return (chunk > 0) ? width / chunk : 1;
  endfunction

  function automatic int serial_cw(input int width, input int chunk);
    int n;
    n = serial_nchunk(width, chunk);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chunked_serial_adder_if.sv
// Operand / result handshake bundle for chunked_serial_adder.
//   in_valid, A, B, Cin, SUB : operation request (master -> slave)
//   in_ready                 : slave can accept a request
//   out_valid, S, Cout, V    : result (slave -> master)
//   out_ready                : master accepts the result
interface chunked_serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             SUB;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             V;

  modport master (
    output in_valid, A, B, Cin, SUB, out_ready,
    input  in_ready, out_valid, S, Cout, V
  );

  modport slave (
    input  in_valid, A, B, Cin, SUB, out_ready,
    output in_ready, out_valid, S, Cout, V
  );
endinterface

// File: rtl/chunked_serial_adder_chunk_adder.sv
// Combinational CHUNK-bit ripple-carry adder built from full-adder cells.
//   a, b     : CHUNK-bit addends
//   ci       : carry in
//   s        : CHUNK-bit sum
//   co       : carry out of the top bit
//   c_msb_in : carry into the top bit (used for signed overflow)
module chunk_adder #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb_in
);

  function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
    // {carry, sum}
    return {(x & y) | (c & (x ^ y)), x ^ y ^ c};
  endfunction

  // The carry chain is a loop variable rather than a vector so the ripple
  // stays a single combinational process.
  always_comb begin
    logic       c;
    logic [1:0] fa;
    c        = ci;
    s        = '0;
    c_msb_in = ci;
    fa       = '0;
    for (int i = 0; i < CHUNK; i++) begin
      if (i == CHUNK - 1) c_msb_in = c;
      fa   = full_add(a[i], b[i], c);
      s[i] = fa[0];
      c    = fa[1];
    end
    co = c;
  end

endmodule

// File: rtl/chunked_serial_adder.sv
// Multi-cycle adder/subtractor processing CHUNK bits per clock.
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset
//   bus  : slave side of chunked_serial_adder_if
//          request  in_valid/in_ready with A, B, Cin, SUB (A-B when SUB=1)
//          response out_valid/out_ready with S, Cout (1 = no borrow on
//          subtract) and V (signed overflow)
// An accepted operation takes WIDTH/CHUNK RUN cycles, low chunk first, then
// holds the result in DONE until out_ready.
module chunked_serial_adder
  import chunked_serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  chunked_serial_adder_if.slave bus
);

  localparam int NCHUNK = serial_nchunk(WIDTH, CHUNK);
  localparam int CW     = serial_cw(WIDTH, CHUNK);
  localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

  if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_param_check
    $error("chunked_serial_adder: WIDTH (%0d) must be a non-zero multiple of CHUNK (%0d)",
           WIDTH, CHUNK);
  end

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] s_r;
  logic             cout_r;
  logic             v_r;
  logic             in_ready_r;
  logic             out_valid_r;

  logic [31:0]      base;
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK-1:0] sum_chunk;
  logic             co_chunk;
  logic             c_msb_chunk;

  // Chunk select: shift the current slice down to bit 0.
  assign base    = 32'(cnt) * 32'(CHUNK);
  assign a_chunk = CHUNK'(a_r >> base);
  assign b_chunk = CHUNK'(b_r >> base);

  chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
    .a        (a_chunk),
    .b        (b_chunk),
    .ci       (carry),
    .s        (sum_chunk),
    .co       (co_chunk),
    .c_msb_in (c_msb_chunk)
  );

  // Control, operand capture and chunk write-back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      carry       <= 1'b0;
      a_r         <= '0;
      b_r         <= '0;
      s_r         <= '0;
      cout_r      <= 1'b0;
      v_r         <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_r        <= bus.A;
            // Subtraction is A + ~B + 1: invert B here, the +1 rides in the carry.
            b_r        <= bus.SUB ? ~bus.B : bus.B;
            carry      <= bus.SUB ? 1'b1 : bus.Cin;
            cnt        <= '0;
            s_r        <= '0;
            in_ready_r <= 1'b0;
            state      <= RUN;
          end
        end
        RUN: begin
          s_r   <= (s_r & ~(CHUNK_MASK << base)) | (WIDTH'(sum_chunk) << base);
          carry <= co_chunk;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(NCHUNK - 1)) begin
            cout_r      <= co_chunk;
            v_r         <= c_msb_chunk ^ co_chunk;
            out_valid_r <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          // in_valid is deliberately ignored here; a new request waits for IDLE.
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.S         = s_r;
  assign bus.Cout      = cout_r;
  assign bus.V         = v_r;

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Bench for chunked_serial_adder: three instances (8/2, 8/8, 16/1) driven
// through their interfaces; directed cases on the 8/2 instance and random
// operations on all three against an arithmetic reference model.
module tb_chunked_serial_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  chunked_serial_adder_if #(.WIDTH(8))  if_a ();
  chunked_serial_adder_if #(.WIDTH(8))  if_b ();
  chunked_serial_adder_if #(.WIDTH(16)) if_c ();

  chunked_serial_adder #(.WIDTH(8),  .CHUNK(2)) u_dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
  chunked_serial_adder #(.WIDTH(8),  .CHUNK(8)) u_dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));
  chunked_serial_adder #(.WIDTH(16), .CHUNK(1)) u_dut_c (.clk(clk), .rst(rst), .bus(if_c.slave));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operation's meaning.
  function automatic void ref_op(input int w, input longint a, input longint b,
                                 input bit cin, input bit sub,
                                 output longint s, output bit co, output bit v);
    longint md, half, sa, sb, u, sr;
    md   = longint'(1) << w;
    half = longint'(1) << (w - 1);
    sa   = (a >= half) ? a - md : a;
    sb   = (b >= half) ? b - md : b;
    if (sub) begin
      u  = a - b;
      co = (a >= b);
      sr = sa - sb;
    end else begin
      u  = a + b + longint'(cin);
      co = (u >= md);
      sr = sa + sb + longint'(cin);
    end
    s = ((u % md) + md) % md;
    v = (sr >= half) || (sr < -half);
  endfunction

  task automatic drive_in(input int which, input logic vld, input logic [15:0] a,
                          input logic [15:0] b, input logic cin, input logic sub);
    case (which)
      0: begin if_a.in_valid = vld; if_a.A = a[7:0]; if_a.B = b[7:0]; if_a.Cin = cin; if_a.SUB = sub; end
      1: begin if_b.in_valid = vld; if_b.A = a[7:0]; if_b.B = b[7:0]; if_b.Cin = cin; if_b.SUB = sub; end
      default: begin if_c.in_valid = vld; if_c.A = a; if_c.B = b; if_c.Cin = cin; if_c.SUB = sub; end
    endcase
  endtask

  task automatic set_ordy(input int which, input logic r);
    case (which)
      0: if_a.out_ready = r;
      1: if_b.out_ready = r;
      default: if_c.out_ready = r;
    endcase
  endtask

  function automatic logic get_ov(input int which);
    return (which == 0) ? if_a.out_valid : (which == 1) ? if_b.out_valid : if_c.out_valid;
  endfunction
  function automatic logic get_ir(input int which);
    return (which == 0) ? if_a.in_ready : (which == 1) ? if_b.in_ready : if_c.in_ready;
  endfunction
  function automatic logic [15:0] get_s(input int which);
    return (which == 0) ? {8'h00, if_a.S} : (which == 1) ? {8'h00, if_b.S} : if_c.S;
  endfunction
  function automatic logic get_co(input int which);
    return (which == 0) ? if_a.Cout : (which == 1) ? if_b.Cout : if_c.Cout;
  endfunction
  function automatic logic get_v(input int which);
    return (which == 0) ? if_a.V : (which == 1) ? if_b.V : if_c.V;
  endfunction

  // Called just after a falling edge. Presents one operation, scrambles the
  // operand inputs after the accept edge, waits for out_valid and optionally
  // drains the result. lat counts rising edges from accept to out_valid.
  task automatic run_op(input int which, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic sub, input bit drain,
                        output logic [15:0] s, output logic co, output logic v, output int lat);
    check_val($sformatf("in_ready_before_op%0d", which), 32'(get_ir(which)), 32'd1);
    drive_in(which, 1'b1, a, b, cin, sub);
    @(negedge clk);
    drive_in(which, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    lat = 0;
    while (!get_ov(which) && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    s  = get_s(which);
    co = get_co(which);
    v  = get_v(which);
    if (drain) begin
      set_ordy(which, 1'b1);
      @(negedge clk);
      set_ordy(which, 1'b0);
    end
  endtask

  task automatic do_rand(input int which, input int w, input int n, input int lat_exp);
    logic [15:0] a, b, mask, s;
    logic        cin, sub, co, v;
    longint      es;
    bit          eco, ev;
    int          lat;
    mask = (w == 16) ? 16'hFFFF : 16'h00FF;
    for (int i = 0; i < n; i++) begin
      a   = 16'($urandom) & mask;
      b   = 16'($urandom) & mask;
      cin = 1'($urandom);
      sub = 1'($urandom);
      ref_op(w, longint'(a), longint'(b), cin, sub, es, eco, ev);
      run_op(which, a, b, cin, sub, 1'b1, s, co, v, lat);
      check_val($sformatf("rnd%0d_s a=%0h b=%0h sub=%0d", which, a, b, sub), 32'(s), 32'(es));
      check_val($sformatf("rnd%0d_cout", which), 32'(co), 32'(eco));
      check_val($sformatf("rnd%0d_v", which), 32'(v), 32'(ev));
      check_val($sformatf("rnd%0d_latency", which), 32'(lat), 32'(lat_exp));
    end
  endtask

  initial begin
    logic [15:0] s;
    logic        co, v;
    int          lat;

    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive_in(k, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      set_ordy(k, 1'b0);
    end
    @(negedge clk);
    @(negedge clk);

    // Reset state of the 8/2 instance.
    check_val("rst_S",         32'(if_a.S),         32'h0);
    check_val("rst_Cout",      32'(if_a.Cout),      32'h0);
    check_val("rst_V",         32'(if_a.V),         32'h0);
    check_val("rst_out_valid", 32'(if_a.out_valid), 32'h0);
    check_val("rst_in_ready",  32'(if_a.in_ready),  32'h1);
    rst = 1'b0;
    @(negedge clk);

    // 0x5A + 0x3C
    run_op(0, 16'h5A, 16'h3C, 1'b0, 1'b0, 1'b1, s, co, v, lat);
    check_val("add_s",   32'(s),   32'h96);
    check_val("add_co",  32'(co),  32'h0);
    check_val("add_v",   32'(v),   32'h1);
    check_val("add_lat", 32'(lat), 32'd4);
    check_val("add_back_idle", 32'(if_a.in_ready), 32'h1);

    // Carry out of the MSB, then carry-in alone.
    run_op(0, 16'hFF, 16'h01, 1'b0, 1'b0, 1'b1, s, co, v, lat);
    check_val("carry_s",  32'(s),  32'h00);
    check_val("carry_co", 32'(co), 32'h1);
    check_val("carry_v",  32'(v),  32'h0);
    run_op(0, 16'h00, 16'h00, 1'b1, 1'b0, 1'b1, s, co, v, lat);
    check_val("cin_s",  32'(s),  32'h01);
    check_val("cin_co", 32'(co), 32'h0);

    // Subtraction with borrow, and with signed overflow.
    run_op(0, 16'h10, 16'h20, 1'b0, 1'b1, 1'b1, s, co, v, lat);
    check_val("sub_borrow_s",  32'(s),  32'hF0);
    check_val("sub_borrow_co", 32'(co), 32'h0);
    check_val("sub_borrow_v",  32'(v),  32'h0);
    run_op(0, 16'h80, 16'h01, 1'b1, 1'b1, 1'b1, s, co, v, lat);
    check_val("sub_ovf_s",  32'(s),  32'h7F);
    check_val("sub_ovf_co", 32'(co), 32'h1);
    check_val("sub_ovf_v",  32'(v),  32'h1);

    // Backpressure in DONE with a competing request.
    run_op(0, 16'h5A, 16'h3C, 1'b0, 1'b0, 1'b0, s, co, v, lat);
    for (int k = 0; k < 5; k++) begin
      drive_in(0, 1'b1, 16'h11, 16'h22, 1'b1, 1'b0);
      @(negedge clk);
      check_val("bp_s",         32'(if_a.S),         32'h96);
      check_val("bp_cout",      32'(if_a.Cout),      32'h0);
      check_val("bp_v",         32'(if_a.V),         32'h1);
      check_val("bp_in_ready",  32'(if_a.in_ready),  32'h0);
      check_val("bp_out_valid", 32'(if_a.out_valid), 32'h1);
    end
    drive_in(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    set_ordy(0, 1'b1);
    @(negedge clk);
    set_ordy(0, 1'b0);
    check_val("bp_drain_in_ready",  32'(if_a.in_ready),  32'h1);
    check_val("bp_drain_out_valid", 32'(if_a.out_valid), 32'h0);
    @(negedge clk);
    check_val("bp_not_taken", 32'(if_a.out_valid), 32'h0);

    // Asynchronous reset after two chunks of 0xAA + 0x55.
    drive_in(0, 1'b1, 16'hAA, 16'h55, 1'b0, 1'b0);
    @(negedge clk);
    drive_in(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("midrst_out_valid", 32'(if_a.out_valid), 32'h0);
    check_val("midrst_S",         32'(if_a.S),         32'h0);
    check_val("midrst_in_ready",  32'(if_a.in_ready),  32'h1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op(0, 16'h01, 16'h01, 1'b0, 1'b0, 1'b1, s, co, v, lat);
    check_val("post_rst_s",   32'(s),   32'h02);
    check_val("post_rst_lat", 32'(lat), 32'd4);

    // Random operations on each configuration.
    do_rand(0, 8, 50, 4);
    do_rand(1, 8, 200, 1);
    do_rand(2, 16, 200, 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
